// File: rtl/fifo_pkg.sv
// Shared helpers for the parametrised FIFO: pointer width and parameter sanity check.
package fifo_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_DEPTH = 8;

   // Pointer width for a DEPTH-entry buffer; a 1-entry buffer still needs one bit.
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Legal parameter sets: power-of-two depth and strictly ordered thresholds.
   function automatic bit params_ok(input int width, input int depth,
                                    input int ae_level, input int af_level);
      return (width >= 1) && (depth >= 2) && ((depth & (depth - 1)) == 0) &&
             (ae_level < af_level) && (af_level <= depth);
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH storage array: synchronous write port, asynchronous read port.
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH,
   localparam int AW   = ptr_width(DEPTH)
) (
   input  logic             clk_10khz,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Storage is deliberately not reset; contents are only meaningful below len.
   always_ff @(posedge clk_10khz) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_param.sv
// Circular-buffer FIFO in the 10 kHz domain with flush, threshold flags,
// sticky overflow/underflow and a one-cycle read-valid strobe.
module fifo_param
   import fifo_pkg::*;
#(
   parameter int WIDTH    = DEFAULT_WIDTH,
   parameter int DEPTH    = DEFAULT_DEPTH,
   parameter int AF_LEVEL = DEPTH - 1,
   parameter int AE_LEVEL = 1
) (
   input  logic                   clk_10khz,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   clear_err,
   input  logic [WIDTH-1:0]       data_in,
   input  logic                   enqueue_in,
   input  logic                   dequeue_in,
   output logic [WIDTH-1:0]       data_out,
   output logic                   data_valid,
   output logic [$clog2(DEPTH):0] len_out,
   output logic                   full,
   output logic                   empty,
   output logic                   almost_full,
   output logic                   almost_empty,
   output logic                   overflow,
   output logic                   underflow
);

   localparam int PW = ptr_width(DEPTH);
   localparam int LW = $clog2(DEPTH) + 1;

   if (!params_ok(WIDTH, DEPTH, AE_LEVEL, AF_LEVEL)) begin : g_bad_params
      $error("fifo_param: DEPTH must be a power of two >= 2 and AE_LEVEL < AF_LEVEL <= DEPTH");
   end

   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [WIDTH-1:0] rd_data;
   logic             deq_acc;
   logic             enq_acc;

   // A dequeue frees a slot in the same edge, so a full FIFO can still accept a write.
   assign deq_acc = dequeue_in && !empty;
   assign enq_acc = enqueue_in && (!full || deq_acc);

   // Status flags decode the registered occupancy only.
   assign full         = (len_out == LW'(DEPTH));
   assign empty        = (len_out == '0);
   assign almost_full  = (len_out >= LW'(AF_LEVEL));
   assign almost_empty = (len_out <= LW'(AE_LEVEL));

   fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk_10khz (clk_10khz),
      .wr_en     (enq_acc && !flush),
      .wr_addr   (wr_ptr),
      .wr_data   (data_in),
      .rd_addr   (rd_ptr),
      .rd_data   (rd_data)
   );

   // Pointers, occupancy and the output register; flush overrides any request.
   always_ff @(posedge clk_10khz or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         len_out    <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
      end else if (flush) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         len_out    <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
      end else begin
         data_valid <= deq_acc;
         if (deq_acc) begin
            data_out <= rd_data;
            rd_ptr   <= rd_ptr + 1'b1;
         end
         if (enq_acc) wr_ptr <= wr_ptr + 1'b1;
         case ({enq_acc, deq_acc})
            2'b10:   len_out <= len_out + 1'b1;
            2'b01:   len_out <= len_out - 1'b1;
            default: len_out <= len_out;
         endcase
      end
   end

   // Sticky error flags; a new error beats clear_err, flush neither raises nor clears.
   always_ff @(posedge clk_10khz or posedge reset) begin
      if (reset) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (!flush && enqueue_in && !enq_acc) overflow <= 1'b1;
         else if (clear_err)                   overflow <= 1'b0;
         if (!flush && dequeue_in && empty)    underflow <= 1'b1;
         else if (clear_err)                   underflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fifo_param.sv
// Directed and model-based bench for fifo_param (WIDTH=8, DEPTH=8).
module tb_fifo_param;

   logic       clk_10khz;
   logic       reset;
   logic       flush;
   logic       clear_err;
   logic [7:0] data_in;
   logic       enqueue_in;
   logic       dequeue_in;
   logic [7:0] data_out;
   logic       data_valid;
   logic [3:0] len_out;
   logic       full;
   logic       empty;
   logic       almost_full;
   logic       almost_empty;
   logic       overflow;
   logic       underflow;

   int total = 0;
   int bad   = 0;

   fifo_param #(.WIDTH(8), .DEPTH(8)) dut (
      .clk_10khz    (clk_10khz),
      .reset        (reset),
      .flush        (flush),
      .clear_err    (clear_err),
      .data_in      (data_in),
      .enqueue_in   (enqueue_in),
      .dequeue_in   (dequeue_in),
      .data_out     (data_out),
      .data_valid   (data_valid),
      .len_out      (len_out),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   initial clk_10khz = 1'b0;
   always #50 clk_10khz = ~clk_10khz;

   typedef struct {
      logic       fl;
      logic       clr;
      logic       enq;
      logic       deq;
      logic [7:0] din;
      logic [7:0] dout;
      logic       valid;
      logic [3:0] len;
      logic       ovf;
      logic       udf;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic [7:0] dout, input logic valid,
                             input logic [3:0] len, input logic ovf, input logic udf);
      chk({tag, ".data_out"},     32'(data_out),     32'(dout));
      chk({tag, ".data_valid"},   32'(data_valid),   32'(valid));
      chk({tag, ".len_out"},      32'(len_out),      32'(len));
      chk({tag, ".full"},         32'(full),         32'(len == 4'd8));
      chk({tag, ".empty"},        32'(empty),        32'(len == 4'd0));
      chk({tag, ".almost_full"},  32'(almost_full),  32'(len >= 4'd7));
      chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(len <= 4'd1));
      chk({tag, ".overflow"},     32'(overflow),     32'(ovf));
      chk({tag, ".underflow"},    32'(underflow),    32'(udf));
   endtask

   task automatic drive(input logic fl, input logic clr, input logic enq,
                        input logic deq, input logic [7:0] din);
      flush      = fl;
      clear_err  = clr;
      enqueue_in = enq;
      dequeue_in = deq;
      data_in    = din;
      @(posedge clk_10khz);
      #1;
   endtask

   task automatic add_vec(input logic fl, input logic clr, input logic enq, input logic deq,
                          input logic [7:0] din, input logic [7:0] dout, input logic valid,
                          input logic [3:0] len, input logic ovf, input logic udf);
      vec_t v;
      v.fl = fl; v.clr = clr; v.enq = enq; v.deq = deq; v.din = din;
      v.dout = dout; v.valid = valid; v.len = len; v.ovf = ovf; v.udf = udf;
      vecs.push_back(v);
   endtask

   initial begin
      logic [7:0] b;
      logic [7:0] q[$];
      logic [7:0] edout;
      logic       evalid, eovf, eudf, enq, deq, clr, dacc, eacc;
      logic [7:0] din;
      int         pe;

      // Fill, overflow attempt, drain, then the empty enq+deq corner.
      for (int i = 1; i <= 8; i++) begin
         b = 8'(8'h11 * i);
         add_vec(0, 0, 1, 0, b, 8'h00, 0, 4'(i), 0, 0);
      end
      add_vec(0, 0, 1, 0, 8'h99, 8'h00, 0, 4'd8, 1, 0);
      for (int i = 1; i <= 8; i++) begin
         b = 8'(8'h11 * i);
         add_vec(0, 0, 0, 1, 8'h00, b, 1, 4'(8 - i), 1, 0);
      end
      add_vec(0, 1, 0, 0, 8'h00, 8'h88, 0, 4'd0, 0, 0);
      add_vec(0, 0, 1, 1, 8'h3C, 8'h88, 0, 4'd1, 0, 1);
      add_vec(0, 0, 0, 1, 8'h00, 8'h3C, 1, 4'd0, 0, 1);
      add_vec(0, 1, 0, 0, 8'h00, 8'h3C, 0, 4'd0, 0, 0);

      reset = 1'b1; flush = 0; clear_err = 0; enqueue_in = 0; dequeue_in = 0; data_in = 0;
      @(posedge clk_10khz); #1;
      @(posedge clk_10khz); #1;
      check_outs("reset", 8'h00, 0, 4'd0, 0, 0);
      reset = 1'b0;

      foreach (vecs[i]) begin
         drive(vecs[i].fl, vecs[i].clr, vecs[i].enq, vecs[i].deq, vecs[i].din);
         check_outs($sformatf("vec%0d", i), vecs[i].dout, vecs[i].valid,
                    vecs[i].len, vecs[i].ovf, vecs[i].udf);
      end

      // Full, then simultaneous enqueue+dequeue keeps len at DEPTH with no overflow.
      for (int i = 1; i <= 8; i++) drive(0, 0, 1, 0, 8'(8'h11 * i));
      drive(0, 0, 1, 1, 8'hA5);
      check_outs("full_both", 8'h11, 1, 4'd8, 0, 0);
      for (int i = 2; i <= 8; i++) begin
         drive(0, 0, 0, 1, 8'h00);
         check_outs($sformatf("full_both_drain%0d", i), 8'(8'h11 * i), 1, 4'(9 - i), 0, 0);
      end
      drive(0, 0, 0, 1, 8'h00);
      check_outs("full_both_last", 8'hA5, 1, 4'd0, 0, 0);

      // Flush at len=5 with a concurrent enqueue; errors preserved.
      drive(0, 0, 0, 1, 8'h00);
      check_outs("udf_set", 8'hA5, 0, 4'd0, 0, 1);
      for (int i = 1; i <= 5; i++) drive(0, 0, 1, 0, 8'(i));
      check_outs("pre_flush", 8'hA5, 0, 4'd5, 0, 1);
      drive(1, 0, 1, 0, 8'h77);
      check_outs("flush", 8'h00, 0, 4'd0, 0, 1);
      drive(0, 1, 0, 0, 8'h00);
      check_outs("clear_err", 8'h00, 0, 4'd0, 0, 0);

      // Async reset pulse mid-cycle clears state before any edge.
      drive(0, 0, 0, 1, 8'h00);
      for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 8'hC0 + 8'(i));
      drive(0, 0, 0, 1, 8'h00);
      check_outs("pre_async", 8'hC0, 1, 4'd2, 0, 1);
      enqueue_in = 0; dequeue_in = 0;
      #20 reset = 1'b1;
      #5 check_outs("async_rst", 8'h00, 0, 4'd0, 0, 0);
      #5 reset = 1'b0;
      drive(0, 0, 1, 0, 8'h5A);
      check_outs("post_rst_enq", 8'h00, 0, 4'd1, 0, 0);
      drive(0, 0, 0, 1, 8'h00);
      check_outs("post_rst_deq", 8'h5A, 1, 4'd0, 0, 0);

      // Random traffic against a queue model; bias alternates to reach full and empty.
      reset = 1'b1;
      @(posedge clk_10khz); #1;
      reset = 1'b0;
      q.delete();
      edout = 8'h00; evalid = 0; eovf = 0; eudf = 0;
      for (int i = 0; i < 1000; i++) begin
         pe  = ((i / 50) % 2 == 0) ? 75 : 25;
         enq = ($urandom_range(0, 99) < pe);
         deq = ($urandom_range(0, 99) < (100 - pe));
         clr = ($urandom_range(0, 29) == 0);
         din = 8'($urandom_range(0, 255));
         dacc = deq && (q.size() > 0);
         eacc = enq && ((q.size() < 8) || dacc);
         if (enq && !eacc) eovf = 1;
         else if (clr)     eovf = 0;
         if (deq && q.size() == 0) eudf = 1;
         else if (clr)             eudf = 0;
         evalid = dacc;
         if (dacc) edout = q.pop_front();
         if (eacc) q.push_back(din);
         drive(0, clr, enq, deq, din);
         check_outs($sformatf("rand%0d", i), edout, evalid, 4'(q.size()), eovf, eudf);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
